sum_it_engine: RTL
==================

// Module: sum_it_engine
// PURPOSE
//  Adder engine at the receiving end of the sumIt packet interface. Captures a burst of
//  WIDTH-bit operands, starting on an active-low go_l strobe, and accumulates them.
//  Publishes the running sum, then a held final result with a done flag.
//  Terminates the packet on a zero operand or after MAX_VALUES operands.
// PARAMETERS
//  WIDTH       16  operand / sum / result width
//  MAX_VALUES  5   max operands per packet (matches valuesToAdd[] depth); must be >= 1
//  CNT_W       $clog2(MAX_VALUES+1)  localparam, width of count
// PORTS
//  clk        in   1        single clock, all state updates on posedge
//  reset_l    in   1        asynchronous, active-low reset
//  go_l       in   1        active-low start strobe, sampled with first operand
//  inA        in   WIDTH    operand; zero marks end of packet
//  sum        out  WIDTH    running accumulator, registered
//  outResult  out  WIDTH    final sum of last completed packet, held
//  done       out  1        level: high from packet completion until next go_l low
//  count      out  CNT_W    operands accepted in current/last packet
//  overflow   out  1        sticky per packet: carry out of WIDTH bits occurred
// BEHAVIOUR
//  Reset (reset_l low, async): state=IDLE; sum, outResult, count = 0; done, overflow = 0.
//  All outputs registered; each reflects the posedge at which inputs were sampled.
//  States IDLE, ACCUM, DONE. go_l low sampled in any state has priority:
//   sum<=inA, count<=1, overflow<=0, done<=0, state<=ACCUM (restart aborts packet in flight).
//  MAX_VALUES==1: a go_l start goes directly to DONE (outResult<=inA, done<=1).
//  IDLE, go_l high: hold all.
//  ACCUM, go_l high:
//   inA==0           -> outResult<=sum, done<=1, state<=DONE; sum/count held.
//   inA!=0           -> sum<=sum+inA (mod 2^WIDTH), count++, overflow|=carry.
//                       If the new count==MAX_VALUES: outResult<=sum+inA (same truncated value),
//                       done<=1, state<=DONE.
//   Zero as the first operand, sampled with go_l: counted (count=1), sum=0.
//  DONE, go_l high: hold sum, outResult, count, overflow; done stays 1; inA ignored.
//  Latency: operand sampled at edge N is visible on sum after edge N.
//   Termination zero at edge N -> done/outResult valid after edge N.
//  outResult changes only on completion; it is not cleared by a new go_l.
//  Reset mid-packet: immediate return to reset values. The packet is discarded.
// STRUCTURE
//  sum_it_pkg: state enum sum_it_state_t {IDLE,ACCUM,DONE}; defaults SUMIT_WIDTH=16,
//   SUMIT_MAX=5; packet typedef sumItPkt_t (valuesToAdd[SUMIT_MAX], howMany) for benches.
//  Sub-module sum_it_accum: WIDTH-bit accumulator register with load/add/hold,
//   carry-out, and sticky overflow. FSM, count and outResult/done stay in the top level.
// TESTING
//  go_l low with inA=55, then inA=22, inA=11, inA=0 ->
//   sum 55,77,88,88; done=1 and outResult=88 after the 4th edge; count=3.
//  Five nonzero operands 1..5, no zero -> done after 5th edge, outResult=15, count=5;
//   a 6th operand is ignored.
//  Overflow: 16'hFFF0 then 16'h0020 then 0 -> outResult=16'h0010, overflow=1;
//   the next packet clears overflow.
//  Restart: go_l low mid-packet (sum=77) with inA=9 -> sum=9, count=1, done=0;
//   prior outResult is unchanged.
//  Reset: assert reset_l low asynchronously between edges during ACCUM ->
//   all outputs 0 immediately. After release, go_l low with inA=0 then inA=0 ->
//   sum=0, done=1, outResult=0, count=1.

Source files
------------

// File: rtl/sum_it_pkg.sv
// Package for the sumIt adder engine.
// Contents:
//   sum_it_state_t  FSM state encoding (IDLE, ACCUM, DONE)
//   SUMIT_WIDTH     default operand/sum width
//   SUMIT_MAX       default maximum operands per packet
//   sumItPkt_t      packet record (valuesToAdd[], howMany) used by benches
package sum_it_pkg;

    localparam int SUMIT_WIDTH = 16;
    localparam int SUMIT_MAX   = 5;
    localparam int SUMIT_CNT_W = $clog2(SUMIT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } sum_it_state_t;

    typedef struct packed {
        logic [SUMIT_MAX-1:0][SUMIT_WIDTH-1:0] valuesToAdd;
        logic [SUMIT_CNT_W-1:0]                howMany;
    } sumItPkt_t;

endpackage

// File: rtl/sum_it_if.sv
// sumIt packet interface between an operand source and the adder engine.
// Handshake: there is no valid/ready pair. go_l low at a clock edge starts
// a packet with inA as its first operand. Every later edge with go_l high
// delivers one more operand on inA, and a zero operand ends the packet.
// The engine answers with registered sum/outResult/done/count/overflow.
// Modports:
//   master  drives go_l, inA; observes the results
//   slave   samples go_l, inA; drives the results
interface sum_it_if #(
    parameter int WIDTH      = 16,
    parameter int MAX_VALUES = 5
) ();
    localparam int CNT_W = $clog2(MAX_VALUES + 1);

    logic             go_l;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] outResult;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output go_l, inA,
        input  sum, outResult, done, count, overflow
    );

    modport slave (
        input  go_l, inA,
        output sum, outResult, done, count, overflow
    );

endinterface

// File: rtl/sum_it_accum.sv
// WIDTH-bit accumulator with load/add/hold and a sticky overflow flag.
// Ports:
//   clk, reset_l  clock, asynchronous active-low reset
//   load          acc <= d, overflow cleared (takes priority over add)
//   add           acc <= acc + d (mod 2^WIDTH), overflow |= carry
//   d             operand
//   acc           registered accumulator value
//   add_result    combinational acc + d, truncated (value acc takes on add)
//   carry         combinational carry out of acc + d
//   overflow      sticky carry flag since the last load
module sum_it_accum #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             load,
    input  logic             add,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] add_result,
    output logic             carry,
    output logic             overflow
);
    logic [WIDTH:0] add_full;

    assign add_full   = {1'b0, acc} + {1'b0, d};
    assign add_result = add_full[WIDTH-1:0];
    assign carry      = add_full[WIDTH];

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            acc      <= d;
            overflow <= 1'b0;
        end else if (add) begin
            acc      <= add_result;
            overflow <= overflow | carry;
        end
    end

endmodule

// File: rtl/sum_it_engine.sv
// sumIt adder engine: accumulates a burst of operands started by go_l low
// and ends the packet on a zero operand or after MAX_VALUES operands.
// Ports:
//   clk, reset_l  clock, asynchronous active-low reset
//   bus           sum_it_if slave: go_l, inA in; sum, outResult, done,
//                 count, overflow out (all registered)
//   dbg_state     current FSM state
module sum_it_engine
    import sum_it_pkg::*;
#(
    parameter int WIDTH      = SUMIT_WIDTH,
    parameter int MAX_VALUES = SUMIT_MAX
) (
    input  logic          clk,
    input  logic          reset_l,
    sum_it_if.slave       bus,
    output sum_it_state_t dbg_state
);
    localparam int CNT_W = $clog2(MAX_VALUES + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VALUES);

    sum_it_state_t    state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt, count_inc;
    logic [WIDTH-1:0] out_result, out_result_nxt;
    logic             done, done_nxt;
    logic             acc_load, acc_add;
    logic [WIDTH-1:0] acc, add_result;
    logic             carry, overflow;

    sum_it_accum #(.WIDTH(WIDTH)) u_accum (
        .clk        (clk),
        .reset_l    (reset_l),
        .load       (acc_load),
        .add        (acc_add),
        .d          (bus.inA),
        .acc        (acc),
        .add_result (add_result),
        .carry      (carry),
        .overflow   (overflow)
    );

    assign count_inc = count + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state      <= IDLE;
            count      <= '0;
            out_result <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            out_result <= out_result_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        out_result_nxt = out_result;
        done_nxt       = done;
        acc_load       = 1'b0;
        acc_add        = 1'b0;

        if (!bus.go_l) begin
            // A start wins in every state, aborting any packet in flight.
            acc_load  = 1'b1;
            count_nxt = CNT_W'(1);
            done_nxt  = 1'b0;
            state_nxt = ACCUM;
            if (MAX_VALUES == 1) begin
                out_result_nxt = bus.inA;
                done_nxt       = 1'b1;
                state_nxt      = DONE;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.inA == '0) begin
                        out_result_nxt = acc;
                        done_nxt       = 1'b1;
                        state_nxt      = DONE;
                    end else begin
                        acc_add   = 1'b1;
                        count_nxt = count_inc;
                        if (count_inc == MAX_CNT) begin
                            out_result_nxt = add_result;
                            done_nxt       = 1'b1;
                            state_nxt      = DONE;
                        end
                    end
                end
                default: ; // IDLE and DONE hold everything
            endcase
        end
    end

    assign bus.sum       = acc;
    assign bus.outResult = out_result;
    assign bus.done      = done;
    assign bus.count     = count;
    assign bus.overflow  = overflow;
    assign dbg_state     = state;

    // carry is folded into overflow inside the accumulator
    logic unused_carry;
    assign unused_carry = carry;

endmodule
